mul_issue_ctrl: RTL
===================

Name: mul_issue_ctrl

Overview:
- RV64M multiply front-end between the execute stage and the iterative unsigned shift-add multiplier.
- Accepts MUL/MULH/MULHSU/MULHU/MULW requests and converts operands to magnitudes plus a sign flag.
- Issues the request to the multiplier, waits a variable number of cycles, applies the sign correction and hi/lo/word selection, then holds the 64-bit result until the consumer takes it.
- Handles pipeline flush and a zero-operand fast path.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- OPW, 3, width of the op code.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  abort any in-flight operation.
- in_valid  input  1  request valid.
- in_ready  output  1  controller can accept a request; high only in IDLE.
- in_op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MULW, 5-7 illegal.
- in_src1  input  64  rs1 operand.
- in_src2  input  64  rs2 operand.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_result  output  64  final rd value.
- mul_req  output  1  one-cycle start pulse to the multiplier.
- mul_kill  output  1  one-cycle abort pulse to the multiplier.
- mul_a  output  64  unsigned multiplicand magnitude, held stable from ISSUE until done or kill.
- mul_b  output  64  unsigned multiplier magnitude, held stable from ISSUE until done or kill.
- mul_ready  input  1  multiplier idle.
- mul_done  input  1  one-cycle pulse; product valid in this cycle.
- mul_prod  input  128  unsigned product of mul_a and mul_b.

Behaviour:
- Reset: state=IDLE; in_ready=1; out_valid=0; out_result=0; mul_req=0; mul_kill=0; mul_a=0; mul_b=0; neg=0. Reset mid-operation returns to IDLE the next cycle with no mul_kill pulse; the multiplier shares rst.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: on in_valid && !flush, latch op and operands.
  - Compute neg:
    - MULH: src1[63]^src2[63].
    - MULHSU: src1[63].
    - MUL, MULHU, MULW: 0.
  - Compute magnitudes:
    - mul_a = (op in {MULH, MULHSU} && src1[63]) ? -src1 : src1.
    - mul_b = (op==MULH && src2[63]) ? -src2 : src2.
    - MULW: mul_a={32'b0,src1[31:0]}, mul_b={32'b0,src2[31:0]}.
  - Zero fast path: if either magnitude is 0 or op is illegal, out_result=0 and go to RESP; the multiplier is never touched.
  - Otherwise go to ISSUE.
- ISSUE: assert mul_req for exactly one cycle when mul_ready=1, then go to WAIT. While mul_ready=0, wait in ISSUE with mul_req=0.
- WAIT: on mul_done, compute P = neg ? (~mul_prod + 1) : mul_prod (128-bit two's complement), select the result, and go to RESP.
  - MUL: P[63:0].
  - MULH, MULHSU, MULHU: P[127:64].
  - MULW: sign-extend P[31:0] to 64 bits.
- RESP: out_valid=1 and out_result held stable. On out_ready, go to IDLE; a new request is not accepted in the same cycle (in_ready=0 in RESP).
- Latency, accept to out_valid:
  - Fast path: 1 cycle.
  - Normal: 1 (ISSUE) + multiplier latency + 1, with mul_ready already high.
- flush has priority over every other event:
  - Any state goes to IDLE on the next edge and out_valid drops.
  - mul_kill pulses for one cycle if the state was WAIT, or ISSUE with mul_req asserted in that cycle.
  - A mul_done in the flush cycle is discarded.
  - A request presented with flush is not accepted.
- mul_done outside WAIT is ignored. Requirement on the multiplier: no mul_done after mul_kill.
- Back-to-back operation: RESP to IDLE to accept, so the minimum spacing between accepts is 2 cycles.

Decomposition:
- Shared package (mdu_pkg):
  - Op code constants MUL_OP_MUL..MUL_OP_MULW.
  - State encoding localparams.
  - XLEN.
- Optional sub-module mul_sign_fix: combinational 128-bit conditional negate plus op-based result select. It is reused by the future divider front-end.

Test Plan:
- MULH: src1=src2=0x8000_0000_0000_0000 -> mul_a=mul_b=0x8000_0000_0000_0000, neg=0, out_result=0x4000_0000_0000_0000.
- MULHSU: src1=0xFFFF_FFFF_FFFF_FFFF, src2=2 -> mul_a=1, neg=1, out_result=0xFFFF_FFFF_FFFF_FFFF. Same operands with MULHU -> 0x0000_0000_0000_0001.
- MULW: src1=0x1234_5678_7FFF_FFFF, src2=2 -> mul_a=0x7FFF_FFFF, out_result=0xFFFF_FFFF_FFFF_FFFE. MUL: 3 x 0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFD.
- Zero fast path: src1=0, op=MULH -> mul_req never asserted, out_valid high exactly 1 cycle after accept, out_result=0. op=6 behaves the same.
- flush asserted 5 cycles into WAIT -> mul_kill pulses once, state=IDLE, out_valid stays 0, and a forced late mul_done is ignored. A next request issues normally.
- Backpressure: out_ready=0 for 10 cycles in RESP -> out_valid and out_result stable, in_ready=0. mul_ready=0 for 3 cycles in ISSUE -> mul_req fires only on the cycle mul_ready rises.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the M-extension front-ends: datapath width,
// op codes and controller state encoding.
package mdu_pkg;

  localparam int XLEN = 64;
  localparam int OPW  = 3;

  localparam logic [OPW-1:0] MUL_OP_MUL    = 3'd0;
  localparam logic [OPW-1:0] MUL_OP_MULH   = 3'd1;
  localparam logic [OPW-1:0] MUL_OP_MULHSU = 3'd2;
  localparam logic [OPW-1:0] MUL_OP_MULHU  = 3'd3;
  localparam logic [OPW-1:0] MUL_OP_MULW   = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } mul_state_e;

endpackage

// File: rtl/mul_sign_fix.sv
// Applies the sign correction to an unsigned 128-bit magnitude product and
// picks the architectural rd value for the op.
module mul_sign_fix
  import mdu_pkg::*;
(
  input  logic [2*XLEN-1:0] i_prod,
  input  logic              i_neg,
  input  logic [OPW-1:0]    i_op,
  output logic [XLEN-1:0]   o_result
);

  logic [2*XLEN-1:0] w_signed;

  always_comb begin
    w_signed = i_neg ? (~i_prod + 128'd1) : i_prod;
    case (i_op)
      MUL_OP_MUL:    o_result = w_signed[XLEN-1:0];
      MUL_OP_MULH,
      MUL_OP_MULHSU,
      MUL_OP_MULHU:  o_result = w_signed[2*XLEN-1:XLEN];
      MUL_OP_MULW:   o_result = {{32{w_signed[31]}}, w_signed[31:0]};
      default:       o_result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mul_issue_ctrl.sv
// RV64M multiply front-end: turns signed requests into magnitudes for the
// iterative unsigned multiplier, then fixes up sign and selects the result.
module mul_issue_ctrl
  import mdu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_flush,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  logic [OPW-1:0]      i_in_op,
  input  logic [XLEN-1:0]     i_in_src1,
  input  logic [XLEN-1:0]     i_in_src2,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic [XLEN-1:0]     o_out_result,
  output logic                o_mul_req,
  output logic                o_mul_kill,
  output logic [XLEN-1:0]     o_mul_a,
  output logic [XLEN-1:0]     o_mul_b,
  input  logic                i_mul_ready,
  input  logic                i_mul_done,
  input  logic [2*XLEN-1:0]   i_mul_prod
);

  mul_state_e          r_state;
  logic [OPW-1:0]      r_op;
  logic                r_neg;
  logic [XLEN-1:0]     r_mul_a;
  logic [XLEN-1:0]     r_mul_b;
  logic [XLEN-1:0]     r_out_result;
  logic                r_out_valid;
  logic                r_mul_kill;

  logic                w_neg;
  logic [XLEN-1:0]     w_mag_a;
  logic [XLEN-1:0]     w_mag_b;
  logic                w_fast;
  logic                w_mul_req;
  logic [XLEN-1:0]     w_result;

  always_comb begin
    w_neg   = 1'b0;
    w_mag_a = i_in_src1;
    w_mag_b = i_in_src2;
    case (i_in_op)
      MUL_OP_MULH: begin
        w_neg   = i_in_src1[63] ^ i_in_src2[63];
        w_mag_a = i_in_src1[63] ? -i_in_src1 : i_in_src1;
        w_mag_b = i_in_src2[63] ? -i_in_src2 : i_in_src2;
      end
      MUL_OP_MULHSU: begin
        w_neg   = i_in_src1[63];
        w_mag_a = i_in_src1[63] ? -i_in_src1 : i_in_src1;
      end
      MUL_OP_MULW: begin
        w_mag_a = {32'd0, i_in_src1[31:0]};
        w_mag_b = {32'd0, i_in_src2[31:0]};
      end
      default: begin
        w_neg = 1'b0;
      end
    endcase
    w_fast = (i_in_op > MUL_OP_MULW) || (w_mag_a == 64'd0) || (w_mag_b == 64'd0);
  end

  // The start pulse must coincide with the multiplier reporting idle, so it
  // follows mul_ready combinationally while in ISSUE.
  assign w_mul_req    = (r_state == ST_ISSUE) && i_mul_ready;
  assign o_mul_req    = w_mul_req;
  assign o_in_ready   = (r_state == ST_IDLE);
  assign o_out_valid  = r_out_valid;
  assign o_out_result = r_out_result;
  assign o_mul_a      = r_mul_a;
  assign o_mul_b      = r_mul_b;
  assign o_mul_kill   = r_mul_kill;

  mul_sign_fix u_sign_fix (
    .i_prod   (i_mul_prod),
    .i_neg    (r_neg),
    .i_op     (r_op),
    .o_result (w_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_op         <= MUL_OP_MUL;
      r_neg        <= 1'b0;
      r_mul_a      <= 64'd0;
      r_mul_b      <= 64'd0;
      r_out_result <= 64'd0;
      r_out_valid  <= 1'b0;
      r_mul_kill   <= 1'b0;
    end else begin
      r_mul_kill <= 1'b0;
      if (i_flush) begin
        // Only abort the multiplier if it may have seen a start pulse.
        r_state     <= ST_IDLE;
        r_out_valid <= 1'b0;
        r_mul_kill  <= (r_state == ST_WAIT) || w_mul_req;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_in_valid) begin
              r_op    <= i_in_op;
              r_neg   <= w_neg;
              r_mul_a <= w_mag_a;
              r_mul_b <= w_mag_b;
              if (w_fast) begin
                r_out_result <= 64'd0;
                r_out_valid  <= 1'b1;
                r_state      <= ST_RESP;
              end else begin
                r_state <= ST_ISSUE;
              end
            end
          end
          ST_ISSUE: begin
            if (i_mul_ready) begin
              r_state <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (i_mul_done) begin
              r_out_result <= w_result;
              r_out_valid  <= 1'b1;
              r_state      <= ST_RESP;
            end
          end
          ST_RESP: begin
            if (i_out_ready) begin
              r_out_valid <= 1'b0;
              r_state     <= ST_IDLE;
            end
          end
          default: begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
